// File: rtl/aes_sbox.sv
// AES forward S-box: GF(2^8) inverse (x^254) followed by the FIPS-197 affine map.
// Optional macro SBOX_COMB_EN makes subByte purely combinational (no register).
module aes_sbox (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] inByte,
    output logic [7:0] subByte
);

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for nonzero x, and naturally maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] y;
        y = gf_mul(x, x);
        y = gf_mul(y, x);
        y = gf_mul(y, y);
        y = gf_mul(y, x);
        y = gf_mul(y, y);
        y = gf_mul(y, x);
        y = gf_mul(y, y);
        y = gf_mul(y, x);
        y = gf_mul(y, y);
        y = gf_mul(y, x);
        y = gf_mul(y, y);
        y = gf_mul(y, x);
        y = gf_mul(y, y);
        return y;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b
             ^ {b[6:0], b[7]}
             ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]}
             ^ 8'h63;
    endfunction

    logic [7:0] w_sub;

    assign w_sub = affine(gf_inv(inByte));

`ifdef SBOX_COMB_EN
    assign subByte = w_sub;
`else
    logic [7:0] r_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= 8'h00;
        end else begin
            r_sub <= w_sub;
        end
    end

    assign subByte = r_sub;
`endif

endmodule

// File: tb/tb_aes_sbox.sv
// Self-checking bench for aes_sbox: directed vectors, exhaustive sweep,
// reset behaviour, checked against an independent search-based reference.
module tb_aes_sbox;

    logic       clk;
    logic       rst_n;
    logic [7:0] inByte;
    logic [7:0] subByte;

    int n_checks;
    int n_errors;

    logic [7:0] sb[$];
    bit         seen[256];

    aes_sbox dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .inByte (inByte),
        .subByte(subByte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [15:0] prod;
        prod = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    // brute-force inverse search plus bitwise affine equation
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        inv = 8'h00;
        for (int k = 1; k < 256; k++)
            if (ref_mul(x, 8'(k)) == 8'h01) inv = 8'(k);
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                 ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    task automatic check(
        input string      tag,
        input logic [7:0] obs,
        input logic [7:0] exp
    );
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

`ifndef SBOX_COMB_EN
    task automatic drive(input string tag, input logic [7:0] v);
        logic [7:0] exp;
        @(negedge clk);
        inByte = v;
        sb.push_back(sbox_ref(v));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, observed %h", tag, subByte);
        end else begin
            exp = sb.pop_front();
            check(tag, subByte, exp);
            seen[subByte] = 1'b1;
        end
    endtask
`endif

    initial begin
        logic [7:0] kv_in  [6];
        logic [7:0] kv_out [6];
        int         n_distinct;

        n_checks = 0;
        n_errors = 0;
        kv_in  = '{8'h00, 8'h01, 8'h10, 8'h53, 8'hC9, 8'hFF};
        kv_out = '{8'h63, 8'h7C, 8'hCA, 8'hED, 8'hDD, 8'h16};

        for (int i = 0; i < 6; i++)
            check("ref_model", sbox_ref(kv_in[i]), kv_out[i]);

`ifdef SBOX_COMB_EN
        rst_n  = 1'b1;
        inByte = 8'hC9;
        #2;
        check("comb_c9", subByte, 8'hDD);
        rst_n = 1'b0;
        #2;
        check("comb_rst_low", subByte, 8'hDD);
        rst_n = 1'b1;
        #2;
        check("comb_rst_high", subByte, 8'hDD);
        for (int v = 0; v < 256; v++) begin
            inByte = 8'(v);
            #1;
            check("comb_sweep", subByte, sbox_ref(8'(v)));
            seen[subByte] = 1'b1;
        end
`else
        rst_n  = 1'b0;
        inByte = 8'h53;
        #1;
        check("reset_t0", subByte, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", subByte, 8'h00);
        end

        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(sbox_ref(inByte));
        @(posedge clk);
        #1;
        check("first_after_rst", subByte, sb.pop_front());
        check("first_is_ed", subByte, 8'hED);

        for (int i = 0; i < 6; i++) begin
            drive("known_vec", kv_in[i]);
            check("known_const", subByte, kv_out[i]);
        end

        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int v = 0; v < 256; v++)
            drive("sweep", 8'(v));

        drive("pre_rst", 8'hA5);
        drive("pre_rst", 8'h3C);
        @(negedge clk);
        inByte = 8'h7E;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_rst", subByte, 8'h00);
        @(posedge clk);
        #1;
        check("async_rst_hold", subByte, 8'h00);
        @(negedge clk);
        rst_n  = 1'b1;
        inByte = 8'h9A;
        sb.push_back(sbox_ref(8'h9A));
        @(posedge clk);
        #1;
        check("resume_first", subByte, sb.pop_front());
        drive("resume", 8'h01);
        drive("resume", 8'hC9);
        drive("resume", 8'h53);
        drive("resume", 8'hFF);
`endif

        n_distinct = 0;
        for (int i = 0; i < 256; i++)
            if (seen[i]) n_distinct++;
        check("distinct_lo", 8'(n_distinct), 8'h00);
        n_checks++;
        assert (n_distinct == 256)
        else begin
            n_errors++;
            $error("FAIL distinct: observed %0d expected 256", n_distinct);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
